// File: rtl/tt_mux_pkg.sv
// Shared types and bus layout for the project-mux controller.
package tt_mux_pkg;

    localparam int unsigned IW_W   = 18;
    localparam int unsigned OW_W   = 24;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned BYTE_W = 8;

    localparam int unsigned IW_CLK_OFF   = 0;
    localparam int unsigned IW_RST_N_OFF = 1;
    localparam int unsigned IW_UI_OFF    = 2;
    localparam int unsigned IW_UIO_OFF   = 10;

    localparam int unsigned OW_UO_OFF      = 0;
    localparam int unsigned OW_UIO_OUT_OFF = 8;
    localparam int unsigned OW_UIO_OE_OFF  = 16;

    localparam logic [ADDR_W-1:0] ADDR_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ARM,
        ST_RUN
    } state_e;

endpackage

// File: rtl/tt_mux_ow_sel.sv
// Selects one project's output slice and registers it; zero when not enabled.
module tt_mux_ow_sel
    import tt_mux_pkg::*;
#(
    parameter int unsigned NPROJ = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [ADDR_W-1:0]      sel,
    input  logic [OW_W*NPROJ-1:0]  ow_all,
    output logic [BYTE_W-1:0]      uo_out,
    output logic [BYTE_W-1:0]      uio_out,
    output logic [BYTE_W-1:0]      uio_oe
);

    logic [OW_W-1:0] out_q, out_d;

    always_comb begin
        out_d = '0;
        if (en) begin
            for (int k = 0; k < int'(NPROJ); k++) begin
                if (sel == ADDR_W'(k)) out_d = ow_all[k*OW_W +: OW_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign uo_out  = out_q[OW_UO_OFF      +: BYTE_W];
    assign uio_out = out_q[OW_UIO_OUT_OFF +: BYTE_W];
    assign uio_oe  = out_q[OW_UIO_OE_OFF  +: BYTE_W];

endmodule

// File: rtl/tt_mux_ctrl.sv
// Project-select controller: drains the old project, arms the new one under
// reset with a divided clock, then routes host I/O to it while running.
module tt_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int unsigned NPROJ      = 8,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sel_valid,
    input  logic [ADDR_W-1:0]      sel_addr,
    output logic                   sel_ready,
    input  logic [BYTE_W-1:0]      host_ui_in,
    input  logic [BYTE_W-1:0]      host_uio_in,
    input  logic                   host_proj_rst_n,
    output logic [NPROJ-1:0]       ena,
    output logic [IW_W-1:0]        iw,
    input  logic [OW_W*NPROJ-1:0]  ow_all,
    output logic [BYTE_W-1:0]      uo_out,
    output logic [BYTE_W-1:0]      uio_out,
    output logic [BYTE_W-1:0]      uio_oe,
    output logic [ADDR_W-1:0]      active_addr,
    output logic                   busy
);

    localparam int unsigned CNT_W = 4;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pending_q, pending_d;
    logic [1:0]          drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                clk_ph_q, clk_ph_d;
    logic [NPROJ-1:0]    ena_q, ena_d;
    logic [IW_W-1:0]     iw_q, iw_d;
    logic [ADDR_W-1:0]   active_q, active_d;
    logic                busy_q, busy_d;
    logic                sel_ready_q, sel_ready_d;
    logic                accept_c;
    logic                run_next_c;

    function automatic logic [NPROJ-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NPROJ-1:0] res;
        res = '0;
        for (int k = 0; k < int'(NPROJ); k++) begin
            if (a == ADDR_W'(k)) res[k] = 1'b1;
        end
        return res;
    endfunction

    // Next state and the registered output values for the coming cycle.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        drain_cnt_d = drain_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        clk_ph_d    = 1'b0;
        ena_d       = '0;
        iw_d        = '0;
        active_d    = ADDR_NONE;
        busy_d      = 1'b0;
        sel_ready_d = 1'b0;
        accept_c    = sel_valid && sel_ready_q;

        if (accept_c) pending_d = sel_addr;

        case (state_q)
            ST_IDLE: begin
                if (accept_c && (32'(sel_addr) < NPROJ)) begin
                    state_d    = ST_ARM;
                    edge_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 2'd1;
                if (drain_cnt_q == 2'd2) begin
                    state_d     = (32'(pending_q) < NPROJ) ? ST_ARM : ST_IDLE;
                    drain_cnt_d = '0;
                    edge_cnt_d  = '0;
                end
            end
            ST_ARM: begin
                // Rising edge happens in cycles where the divided clock is high.
                if (clk_ph_q) begin
                    edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    if (edge_cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_ARM: begin
                clk_ph_d = (state_q == ST_ARM) ? ~clk_ph_q : 1'b1;
                ena_d    = onehot(pending_d);
                busy_d   = 1'b1;
            end
            ST_RUN: begin
                clk_ph_d    = ~clk_ph_q;
                ena_d       = ena_q;
                active_d    = pending_d;
                sel_ready_d = 1'b1;
            end
            ST_DRAIN: begin
                ena_d  = (drain_cnt_d == 2'd2) ? '0 : ena_q;
                busy_d = 1'b1;
            end
            default: sel_ready_d = 1'b1;
        endcase

        iw_d[IW_CLK_OFF] = clk_ph_d;
        if (state_d == ST_RUN) begin
            iw_d[IW_RST_N_OFF]           = host_proj_rst_n;
            iw_d[IW_UI_OFF  +: BYTE_W]   = host_ui_in;
            iw_d[IW_UIO_OFF +: BYTE_W]   = host_uio_in;
        end

        run_next_c = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            drain_cnt_q <= '0;
            edge_cnt_q  <= '0;
            clk_ph_q    <= 1'b0;
            ena_q       <= '0;
            iw_q        <= '0;
            active_q    <= ADDR_NONE;
            busy_q      <= 1'b0;
            sel_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            drain_cnt_q <= drain_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            clk_ph_q    <= clk_ph_d;
            ena_q       <= ena_d;
            iw_q        <= iw_d;
            active_q    <= active_d;
            busy_q      <= busy_d;
            sel_ready_q <= sel_ready_d;
        end
    end

    tt_mux_ow_sel #(.NPROJ(NPROJ)) u_ow_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (run_next_c),
        .sel     (pending_q),
        .ow_all  (ow_all),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    assign sel_ready   = sel_ready_q;
    assign ena         = ena_q;
    assign iw          = iw_q;
    assign active_addr = active_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Scenario bench for tt_mux_ctrl: select/arm/run/drain sequences and output routing.
module tb_tt_mux_ctrl;

    localparam int unsigned NP = 8;
    localparam int unsigned R  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sel_valid = 1'b0;
    logic [3:0]        sel_addr = 4'h0;
    logic              sel_ready;
    logic [7:0]        host_ui_in = 8'h3C;
    logic [7:0]        host_uio_in = 8'hC3;
    logic              host_proj_rst_n = 1'b1;
    logic [NP-1:0]     ena;
    logic [17:0]       iw;
    logic [24*NP-1:0]  ow_all = '0;
    logic [7:0]        uo_out, uio_out, uio_oe;
    logic [3:0]        active_addr;
    logic              busy;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    tt_mux_ctrl #(.NPROJ(NP), .RST_CYCLES(R)) dut (
        .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_addr(sel_addr),
        .sel_ready(sel_ready), .host_ui_in(host_ui_in), .host_uio_in(host_uio_in),
        .host_proj_rst_n(host_proj_rst_n), .ena(ena), .iw(iw), .ow_all(ow_all),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
        .active_addr(active_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_select(input logic [3:0] a);
        int n = 0;
        while (!sel_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (sel_ready !== 1'b1) begin
            errors++;
            $display("FAIL select_wait addr=%h sel_ready=%b required 1", a, sel_ready);
        end
        sel_valid = 1'b1;
        sel_addr  = a;
        step();
        sel_valid = 1'b0;
    endtask

    // Checks an idle-like cycle: nothing enabled, bus quiet, outputs zero.
    task automatic check_quiet(input string name);
        checks++;
        if ({ena, iw, busy, sel_ready, active_addr, uio_oe, uio_out, uo_out} !==
            {8'h00, 18'h0, 1'b0, 1'b1, 4'hF, 24'h0}) begin
            errors++;
            $display("FAIL %s ena=%h iw=%h busy=%b rdy=%b act=%h out=%h required 00/0/0/1/F/0",
                     name, ena, iw, busy, sel_ready, active_addr, {uio_oe, uio_out, uo_out});
        end
    endtask

    // Called on the first ARM cycle; returns on the first RUN cycle.
    task automatic check_arm_to_run(input logic [3:0] a);
        logic [7:0] oh;
        logic       exp_clk;
        logic       prev_clk;
        int         dut_edges;
        oh = 8'h01 << a;
        prev_clk = 1'b0;
        dut_edges = 0;
        for (int c = 0; c < 2*int'(R) - 1; c++) begin
            exp_clk = (c % 2 == 0);
            if (iw[0] && !prev_clk && !iw[1]) dut_edges++;
            prev_clk = iw[0];
            checks++;
            if ({ena, iw, busy, sel_ready, active_addr} !==
                {oh, 16'h0, 1'b0, exp_clk, 1'b1, 1'b0, 4'hF}) begin
                errors++;
                $display("FAIL arm%0d_cyc%0d ena=%h iw=%h busy=%b rdy=%b act=%h required ena=%h clk=%b",
                         a, c, ena, iw, busy, sel_ready, active_addr, oh, exp_clk);
            end
            step();
        end
        checks++;
        if (dut_edges != int'(R)) begin
            errors++;
            $display("FAIL arm%0d_edges got %0d required %0d", a, dut_edges, R);
        end
        checks++;
        if ({ena, iw, busy, sel_ready, active_addr} !==
            {oh, host_uio_in, host_ui_in, host_proj_rst_n, 1'b0, 1'b0, 1'b1, a}) begin
            errors++;
            $display("FAIL run%0d_entry ena=%h iw=%h busy=%b rdy=%b act=%h required ena=%h iw=%h act=%h",
                     a, ena, iw, busy, sel_ready, active_addr, oh,
                     {host_uio_in, host_ui_in, host_proj_rst_n, 1'b0}, a);
        end
    endtask

    // Called on the first DRAIN cycle; returns on the cycle after the gap.
    task automatic check_drain(input logic [3:0] old_a);
        logic [7:0] exp_ena;
        for (int d = 0; d < 3; d++) begin
            exp_ena = (d < 2) ? (8'h01 << old_a) : 8'h00;
            checks++;
            if ({ena, iw, busy, sel_ready, active_addr, uio_oe, uio_out, uo_out} !==
                {exp_ena, 18'h0, 1'b1, 1'b0, 4'hF, 24'h0}) begin
                errors++;
                $display("FAIL drain%0d_cyc%0d ena=%h iw=%h busy=%b rdy=%b act=%h out=%h required ena=%h",
                         old_a, d, ena, iw, busy, sel_ready, active_addr,
                         {uio_oe, uio_out, uo_out}, exp_ena);
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        check_quiet("reset_held");
        rst_n = 1'b1;
        step();
        check_quiet("reset_released");
    endtask

    task automatic test_select_arm();
        do_select(4'd3);
        check_arm_to_run(4'd3);
        step();
        checks++;
        if (iw[0] !== 1'b1) begin
            errors++;
            $display("FAIL run3_clk_toggle got %b required 1", iw[0]);
        end
    endtask

    task automatic test_ow_route();
        logic [23:0] pats[4];
        logic [23:0] e;
        pats[0] = 24'hA55AC3;
        pats[1] = 24'h000000;
        pats[2] = 24'hFFFFFF;
        pats[3] = 24'h123456;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < int'(NP); k++) ow_all[k*24 +: 24] = 24'($urandom);
            ow_all[3*24 +: 24] = pats[p];
            exp_q.push_back(pats[p]);
            step();
            e = exp_q.pop_front();
            checks++;
            if ({uio_oe, uio_out, uo_out} !== e) begin
                errors++;
                $display("FAIL ow_route%0d oe/out/uo=%h required %h", p,
                         {uio_oe, uio_out, uo_out}, e);
            end
        end
    endtask

    task automatic test_switch();
        do_select(4'd5);
        check_drain(4'd3);
        check_arm_to_run(4'd5);
    endtask

    task automatic test_deselect();
        do_select(4'd2);
        check_drain(4'd5);
        check_arm_to_run(4'd2);
        do_select(4'hC);
        check_drain(4'd2);
        check_quiet("deselect_idle");
        do_select(4'd8);
        check_quiet("idle_addr_nproj");
        do_select(4'd7);
        check_arm_to_run(4'd7);
    endtask

    task automatic test_hold_and_reset();
        do_select(4'd1);
        sel_valid = 1'b1;
        sel_addr  = 4'd6;
        check_drain(4'd7);
        check_arm_to_run(4'd1);
        step();
        sel_valid = 1'b0;
        check_drain(4'd1);
        step();
        step();
        checks++;
        if ({ena, busy, sel_ready} !== {8'h40, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL arm6_mid ena=%h busy=%b rdy=%b required 40/1/0", ena, busy, sel_ready);
        end
        rst_n = 1'b0;
        step();
        check_quiet("reset_mid_arm");
        rst_n = 1'b1;
        step();
        check_quiet("idle_after_reset");
    endtask

    initial begin
        test_reset();
        test_select_arm();
        test_ow_route();
        test_switch();
        test_deselect();
        test_hold_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
